// File: rtl/fpu_pkg.sv
// Shared types and binary32 field constants for the byte-serial adder front end.
package fpu_pkg;

   typedef enum logic [1:0] {
      S_RX   = 2'd0,
      S_WAIT = 2'd1,
      S_TX   = 2'd2
   } state_t;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;

   localparam logic [31:0] FP_ZERO = 32'h0;

   // A zero exponent field covers both true zero and denormals (flushed to zero).
   function automatic logic exp_is_zero(input logic [31:0] x);
      return x[EXP_MSB:EXP_LSB] == '0;
   endfunction

endpackage

// File: rtl/fpu_add_link_if.sv
// 8-bit link carrying operand bytes in and result bytes out.
interface fpu_add_link_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/fpu_zero_bypass.sv
// Replaces the adder sum when an operand is zero/denormal, since the adder
// always assumes a hidden 1.
module fpu_zero_bypass
   import fpu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] sum,
   output logic [31:0] result,
   output logic        bypass
);

   logic za;
   logic zb;

   assign za = exp_is_zero(a);
   assign zb = exp_is_zero(b);

   always_comb begin
      result = sum;
      bypass = 1'b0;
      if (za && zb) begin
         result           = FP_ZERO;
         result[SIGN_BIT] = a[SIGN_BIT] & b[SIGN_BIT];
         bypass           = 1'b1;
      end else if (za) begin
         result = b;
         bypass = 1'b1;
      end else if (zb) begin
         result = a;
         bypass = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_add_link.sv
// Collects two binary32 operands byte-serially, waits on the external adder,
// and streams the (possibly bypassed) sum back MSB-first.
module fpu_add_link
   import fpu_pkg::*;
#(
   parameter int ADD_LAT = 2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   fpu_add_link_if.slave         link,
   output logic [31:0]           add_a,
   output logic [31:0]           add_b,
   input  logic [31:0]           add_s,
   output logic                  busy,
   output logic                  bypass
);

   localparam logic [2:0] WAIT_LOAD = 3'(ADD_LAT - 1);

   state_t      state_reg, state_next;
   logic [2:0]  rx_cnt_reg, rx_cnt_next;
   logic [2:0]  wait_cnt_reg, wait_cnt_next;
   logic        wait_go_reg, wait_go_next;
   logic [1:0]  tx_cnt_reg, tx_cnt_next;
   logic [31:0] add_a_reg, add_a_next;
   logic [31:0] add_b_reg, add_b_next;
   logic [31:0] result_reg, result_next;
   logic [7:0]  tx_data_reg, tx_data_next;
   logic        tx_valid_reg, tx_valid_next;
   logic        busy_reg, busy_next;
   logic        bypass_reg, bypass_next;

   logic [31:0] sel_result;
   logic        sel_bypass;

   fpu_zero_bypass u_bypass (
      .a      (add_a_reg),
      .b      (add_b_reg),
      .sum    (add_s),
      .result (sel_result),
      .bypass (sel_bypass)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_RX;
         rx_cnt_reg   <= '0;
         wait_cnt_reg <= '0;
         wait_go_reg  <= 1'b0;
         tx_cnt_reg   <= '0;
         add_a_reg    <= FP_ZERO;
         add_b_reg    <= FP_ZERO;
         result_reg   <= FP_ZERO;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         bypass_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rx_cnt_reg   <= rx_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
         wait_go_reg  <= wait_go_next;
         tx_cnt_reg   <= tx_cnt_next;
         add_a_reg    <= add_a_next;
         add_b_reg    <= add_b_next;
         result_reg   <= result_next;
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
         busy_reg     <= busy_next;
         bypass_reg   <= bypass_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rx_cnt_next   = rx_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      wait_go_next  = wait_go_reg;
      tx_cnt_next   = tx_cnt_reg;
      add_a_next    = add_a_reg;
      add_b_next    = add_b_reg;
      result_next   = result_reg;
      tx_data_next  = tx_data_reg;
      tx_valid_next = tx_valid_reg;
      busy_next     = busy_reg;
      bypass_next   = bypass_reg;

      case (state_reg)
         S_RX: begin
            if (link.rx_valid) begin
               {add_a_next, add_b_next} = {add_a_reg[23:0], add_b_reg, link.rx_data};
               rx_cnt_next = rx_cnt_reg + 3'd1;
               if (rx_cnt_reg == 3'd7) begin
                  state_next    = S_WAIT;
                  wait_cnt_next = WAIT_LOAD;
                  wait_go_next  = 1'b0;
                  busy_next     = 1'b1;
               end
            end
         end
         S_WAIT: begin
            // The first cycle is the one in which the adder sees the complete operands.
            if (!wait_go_reg) begin
               wait_go_next = 1'b1;
            end else if (wait_cnt_reg != 3'd0) begin
               wait_cnt_next = wait_cnt_reg - 3'd1;
            end else begin
               result_next   = sel_result;
               bypass_next   = sel_bypass;
               tx_data_next  = sel_result[31:24];
               tx_valid_next = 1'b1;
               tx_cnt_next   = 2'd0;
               state_next    = S_TX;
            end
         end
         S_TX: begin
            if (tx_valid_reg && link.tx_ready) begin
               if (tx_cnt_reg == 2'd3) begin
                  tx_valid_next = 1'b0;
                  busy_next     = 1'b0;
                  rx_cnt_next   = 3'd0;
                  state_next    = S_RX;
               end else begin
                  // Shift the result so the next byte is always in [23:16].
                  result_next  = {result_reg[23:0], 8'h00};
                  tx_data_next = result_reg[23:16];
                  tx_cnt_next  = tx_cnt_reg + 2'd1;
               end
            end
         end
         default: state_next = S_RX;
      endcase
   end

   assign link.rx_ready = (state_reg == S_RX);
   assign link.tx_data  = tx_data_reg;
   assign link.tx_valid = tx_valid_reg;
   assign add_a         = add_a_reg;
   assign add_b         = add_b_reg;
   assign busy          = busy_reg;
   assign bypass        = bypass_reg;

endmodule

// File: tb/tb_fpu_add_link.sv
// Directed bench: instance 0 uses ADD_LAT=2, instances 1/2 use ADD_LAT=1/7 for latency sweep.
module tb_fpu_add_link;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]        rx_valid, tx_ready, rx_ready, tx_valid, busy, bypass;
   logic [2:0][7:0]   rx_data, tx_data;
   logic [2:0][31:0]  add_a, add_b, add_s, m_a, m_b, m_sum;
   int                hs_cnt [3];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic int lat_of(int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 7;
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 7;
      logic [31:0] pipe [8];
      fpu_add_link_if bus ();

      assign bus.rx_data  = rx_data[gi];
      assign bus.rx_valid = rx_valid[gi];
      assign bus.tx_ready = tx_ready[gi];
      assign rx_ready[gi] = bus.rx_ready;
      assign tx_data[gi]  = bus.tx_data;
      assign tx_valid[gi] = bus.tx_valid;

      fpu_add_link #(.ADD_LAT(LAT)) dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .link   (bus),
         .add_a  (add_a[gi]),
         .add_b  (add_b[gi]),
         .add_s  (add_s[gi]),
         .busy   (busy[gi]),
         .bypass (bypass[gi])
      );

      // Adder model: LAT register stages; garbage unless the expected operands are presented.
      always @(posedge clk) begin
         pipe[0] <= (add_a[gi] == m_a[gi] && add_b[gi] == m_b[gi]) ? m_sum[gi] : 32'hBAD0BAD0;
         for (int s = 1; s < 8; s++) pipe[s] <= pipe[s-1];
      end
      assign add_s[gi] = pipe[LAT-1];
   end

   always @(posedge clk)
      for (int k = 0; k < 3; k++)
         if (rx_valid[k] && rx_ready[k]) hs_cnt[k] <= hs_cnt[k] + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic rx_byte(int k, logic [7:0] b, bit keep_valid, output bit ok);
      rx_data[k]  = b;
      rx_valid[k] = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rx_ready[k]) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
      end
      if (!keep_valid) rx_valid[k] = 1'b0;
   endtask

   task automatic send_bytes(int k, logic [31:0] a, logic [31:0] b, int n, bit keep_valid);
      logic [63:0] w;
      bit ok;
      w = {a, b};
      for (int i = 0; i < n; i++) begin
         rx_byte(k, w[63-8*i -: 8], keep_valid, ok);
         if (!ok) begin
            check("rx_timeout", 32'd0, 32'd1);
            return;
         end
      end
   endtask

   // Counts edges from the 8th rx handshake until tx_valid; checks operands stay put.
   task automatic wait_tx(int k, logic [31:0] a, logic [31:0] b, output int lat, output bit hold_ok);
      lat = -1;
      hold_ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (add_a[k] !== a || add_b[k] !== b) hold_ok = 1'b0;
         if (rx_ready[k]) hold_ok = 1'b0;
         if (tx_valid[k]) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic collect(int k, output logic [31:0] word, output bit rdy_low, output bit ok);
      word = '0;
      rdy_low = 1'b1;
      ok = 1'b1;
      tx_ready[k] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bit got;
         got = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rx_ready[k]) rdy_low = 1'b0;
            if (tx_valid[k]) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            ok = 1'b0;
            return;
         end
         word = {word[23:0], tx_data[k]};
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      logic [31:0] res;
      logic        byp;
   } vec_t;

   task automatic run_frame(int k, vec_t v);
      int lat;
      bit hold_ok, rdy_low, ok;
      logic [31:0] word;
      int hs0;
      m_a[k] = v.a; m_b[k] = v.b; m_sum[k] = v.sum;
      tx_ready[k] = 1'b1;
      hs0 = hs_cnt[k];
      send_bytes(k, v.a, v.b, 8, 1'b0);
      wait_tx(k, v.a, v.b, lat, hold_ok);
      collect(k, word, rdy_low, ok);
      $display("frame %s: a=%h b=%h -> %h bypass=%b latency=%0d", v.name, v.a, v.b, word, bypass[k], lat);
      check({v.name, "_latency"}, 32'(lat), 32'(lat_of(k) + 1));
      check({v.name, "_hold"}, {31'd0, hold_ok}, 32'd1);
      check({v.name, "_tx_done"}, {31'd0, ok}, 32'd1);
      check({v.name, "_result"}, word, v.res);
      check({v.name, "_bypass"}, {31'd0, bypass[k]}, {31'd0, v.byp});
      check({v.name, "_busy_low"}, {31'd0, busy[k]}, 32'd0);
      check({v.name, "_rx_ready"}, {31'd0, rx_ready[k]}, 32'd1);
      check({v.name, "_rx_count"}, 32'(hs_cnt[k] - hs0), 32'd8);
   endtask

   vec_t vecs [7];

   initial begin
      logic [31:0] word;
      bit rdy_low, ok, hold_ok;
      int lat;
      bit bp_data, bp_valid, bp_rdy;
      int hs0;

      vecs[0] = '{"basic",     32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0};
      vecs[1] = '{"opp_sign",  32'h3FC00000, 32'hBF000000, 32'h3F800000, 32'h3F800000, 1'b0};
      vecs[2] = '{"zero_a",    32'h00000000, 32'h40490FDB, 32'hDEADBEEF, 32'h40490FDB, 1'b1};
      vecs[3] = '{"negzero2",  32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'h80000000, 1'b1};
      vecs[4] = '{"denorm_b",  32'h40490FDB, 32'h00000001, 32'hDEADBEEF, 32'h40490FDB, 1'b1};
      vecs[5] = '{"mixzero",   32'h80000000, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b1};
      vecs[6] = '{"inf",       32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000, 1'b0};

      rx_valid = '0; tx_ready = '0; rx_data = '0;
      m_a = '0; m_b = '0; m_sum = '0;
      for (int k = 0; k < 3; k++) hs_cnt[k] = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_ready", {31'd0, rx_ready[0]}, 32'd1);
      check("reset_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
      check("reset_busy",     {31'd0, busy[0]}, 32'd0);
      check("reset_bypass",   {31'd0, bypass[0]}, 32'd0);
      check("reset_add_a",    add_a[0], 32'd0);
      check("reset_tx_data",  {24'd0, tx_data[0]}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_frame(0, vecs[i]);

      // Backpressure on the first result byte.
      m_a[0] = vecs[0].a; m_b[0] = vecs[0].b; m_sum[0] = vecs[0].sum;
      tx_ready[0] = 1'b0;
      send_bytes(0, vecs[0].a, vecs[0].b, 8, 1'b0);
      wait_tx(0, vecs[0].a, vecs[0].b, lat, hold_ok);
      check("bp_latency", 32'(lat), 32'd3);
      bp_data = 1'b1; bp_valid = 1'b1; bp_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (tx_data[0] !== 8'h40) bp_data = 1'b0;
         if (tx_valid[0] !== 1'b1) bp_valid = 1'b0;
         if (rx_ready[0] !== 1'b0) bp_rdy = 1'b0;
      end
      check("bp_data_held",  {31'd0, bp_data}, 32'd1);
      check("bp_valid_held", {31'd0, bp_valid}, 32'd1);
      check("bp_rx_ready_low", {31'd0, bp_rdy}, 32'd1);
      collect(0, word, rdy_low, ok);
      $display("frame backpressure: -> %h", word);
      check("bp_result", word, 32'h40400000);
      check("bp_rx_ready_until_done", {31'd0, rdy_low}, 32'd1);
      check("bp_rx_ready_after", {31'd0, rx_ready[0]}, 32'd1);

      // Reset in the middle of a frame.
      m_a[0] = vecs[1].a; m_b[0] = vecs[1].b; m_sum[0] = vecs[1].sum;
      send_bytes(0, vecs[1].a, vecs[1].b, 5, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("frame reset_mid: add_a=%h add_b=%h rx_ready=%b", add_a[0], add_b[0], rx_ready[0]);
      check("rst_add_a",    add_a[0], 32'd0);
      check("rst_add_b",    add_b[0], 32'd0);
      check("rst_tx_data",  {24'd0, tx_data[0]}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
      check("rst_busy",     {31'd0, busy[0]}, 32'd0);
      check("rst_bypass",   {31'd0, bypass[0]}, 32'd0);
      check("rst_rx_ready", {31'd0, rx_ready[0]}, 32'd1);
      run_frame(0, vecs[1]);

      // Latency sweep with rx_valid held high throughout.
      for (int k = 1; k < 3; k++) begin
         m_a[k] = vecs[0].a; m_b[k] = vecs[0].b; m_sum[k] = vecs[0].sum;
         tx_ready[k] = 1'b0;
         hs0 = hs_cnt[k];
         send_bytes(k, vecs[0].a, vecs[0].b, 8, 1'b1);
         rx_data[k] = 8'hEE;
         wait_tx(k, vecs[0].a, vecs[0].b, lat, hold_ok);
         collect(k, word, rdy_low, ok);
         rx_valid[k] = 1'b0;
         $display("frame sweep lat=%0d: -> %h latency=%0d", lat_of(k), word, lat);
         check("sweep_latency", 32'(lat), 32'(lat_of(k) + 1));
         check("sweep_result", word, 32'h40400000);
         check("sweep_no_extra_rx", 32'(hs_cnt[k] - hs0), 32'd8);
         check("sweep_hold", {31'd0, hold_ok}, 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpu_add_link.md
Name: fpu_add_link

Overview:
- Byte-serial front end for the single-precision adder.
- Collects two IEEE-754 binary32 operands from the ESP32-side 8-bit link and presents them to the adder.
- Waits the adder's fixed latency, captures the sum and streams it back as 4 bytes.
- Substitutes a correct result when an operand is zero or denormal, because the adder assumes a hidden 1 on both operands.

Parameters:
- ADD_LAT, 2, cycles from operands driven on add_a/add_b to add_s being valid; range 1..7.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  operand byte from link.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts rx byte.
- tx_data  out  8  result byte to link.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  link accepts tx byte.
- add_a  out  32  operand A to adder.
- add_b  out  32  operand B to adder.
- add_s  in  32  adder sum.
- busy  out  1  high outside S_RX.
- bypass  out  1  last result came from zero bypass, not add_s.

Behaviour:
- Transfer rule: a byte moves on a rising edge where valid && ready.
- rx_ready = (state == S_RX), registered-state decode.
- tx_data and tx_valid are registers. They stay stable while tx_valid && !tx_ready.
- Reset (rst_n low at posedge, any state):
  - state = S_RX, byte counter = 0, wait counter = 0.
  - add_a = add_b = 0, result = 0, tx_data = 0, tx_valid = 0, busy = 0, bypass = 0.
  - A partial frame or pending result is discarded.
- S_RX:
  - Accepts 8 bytes: A[31:24], A[23:16], A[15:8], A[7:0], then B in the same order, shifted into add_a/add_b.
  - On the 8th accepted byte: next state is S_WAIT, wait counter loads ADD_LAT-1, busy rises next cycle.
  - rx_ready is low from the cycle after the 8th byte.
- S_WAIT:
  - add_a/add_b are held constant.
  - Wait counter decrements each cycle.
  - When it reads 0:
    - result = bypass value if bypass applies, else add_s.
    - bypass flag is updated.
    - tx_data = result[31:24], tx_valid = 1, state → S_TX, tx byte counter = 0.
  - Latency: 8th rx byte edge to tx_valid high = ADD_LAT+1 edges.
- Bypass rule (exponent field == 0 means zero; denormals are flushed):
  - expA==0 && expB!=0 → B.
  - expB==0 && expA!=0 → A.
  - Both zero → {signA & signB, 31'b0}.
  - Neither zero → add_s.
  - Exponent 255 (inf/NaN) gets no special handling; it passes to the adder.
- S_TX:
  - On each tx handshake, send the next byte MSB-first.
  - After the 4th accepted byte: tx_valid = 0, busy = 0, state → S_RX, rx counter = 0.
  - The rx_ready high cycle follows.
- rx_valid while not ready is ignored and nothing is buffered. tx_ready while !tx_valid has no effect.
- No FIFO; one operation in flight.
- Counters:
  - rx byte counter is 3 bits, wraps only through S_RX exit.
  - tx counter is 2 bits.

Decomposition:
- Shared package fpu_pkg:
  - State encoding S_RX=2'd0, S_WAIT=2'd1, S_TX=2'd2.
  - Binary32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23.
  - FP_ZERO=32'h0.
- One natural sub-module: fpu_zero_bypass, combinational; inputs A, B, sum; outputs selected result and bypass flag.
- The top-level FSM, counters and byte shifting stay in fpu_add_link.
- The adder is instantiated by the parent, not inside this block.

Test Plan:
- Basic add:
  - Stimulus: rx bytes 3F 80 00 00 40 00 00 00, tx_ready=1, adder model returns 40400000 after ADD_LAT.
  - Expected: tx bytes 40 40 00 00, bypass=0, busy low after 4th byte.
- Opposite signs:
  - Stimulus: 3F C0 00 00 BF 00 00 00.
  - Expected: tx 3F 80 00 00.
  - Check: add_a=3FC00000 and add_b=BF000000 are held stable for the whole of S_WAIT.
- Zero bypass:
  - Case 1 stimulus: 00 00 00 00 40 49 0F DB, adder model driving DEADBEEF. Expected: tx 40 49 0F DB, bypass=1.
  - Case 2 stimulus: 80 00 00 00 80 00 00 00. Expected: tx 80 00 00 00.
- Backpressure:
  - Stimulus: tx_ready low for 5 cycles after tx_valid rises on the first result byte (40).
  - Expected: tx_data held at 40 and tx_valid held high; rx_ready stays 0 until the 4th byte is accepted.
- Reset mid-operation:
  - Stimulus: 5 rx bytes, then rst_n low for 1 cycle.
  - Expected: all outputs 0, rx_ready=1. A fresh full 8-byte frame then produces the correct 4-byte result.
- Latency sweep:
  - Stimulus: ADD_LAT = 1 and 7, continuous rx_valid.
  - Expected: tx_valid rises exactly ADD_LAT+1 edges after the 8th rx handshake. No extra rx bytes are accepted while busy.
